// File: rtl/dekatron_pkg.sv
// Shared types and constants for the dekatron guide-pulse sequencer.
// Holds the sequencer state encoding, the guide index constants, the
// default pulse timing and a helper that decodes a state into guide drives.
package dekatron_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    G1   = 3'd2,
    G2   = 3'd3,
    POST = 3'd4
  } seqState_t;

  // Bit positions of the guide drives inside PulsesOut.
  localparam logic GUIDE_RIGHT = 1'b1;
  localparam logic GUIDE_LEFT  = 1'b0;

  // Default timing, in hsClk cycles, and default step-count width.
  localparam int DEF_PRE_GAP  = 2;
  localparam int DEF_PULSE_W  = 3;
  localparam int DEF_POST_GAP = 2;
  localparam int DEF_STEP_W   = 4;

  // Guide drive pattern for a given phase. Incrementing fires the right
  // guide first; decrementing reverses the order.
  function automatic logic [1:0] guideDrive(input seqState_t st, input logic dec);
    logic [1:0] drv;
    drv = 2'b00;
    case (st)
      G1:      drv[dec ? GUIDE_LEFT : GUIDE_RIGHT] = 1'b1;
      G2:      drv[dec ? GUIDE_RIGHT : GUIDE_LEFT] = 1'b1;
      default: drv = 2'b00;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/dekatron_step_sequencer_phase_timer.sv
// dekatron_phase_timer: loadable down-counter with a terminal-count flag.
// Loaded with (duration - 1) on entry to each phase; tc is high in the
// last cycle of the phase.
module dekatron_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             hsClk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge hsClk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= loadVal;
    end else if (count_r != '0) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == '0);

endmodule

// File: rtl/dekatron_step_sequencer.sv
// dekatron_step_sequencer: issues N two-phase guide-pulse sequences for a
// dekatron tube on request, then pulses Done.
// Optional feature: define DEKATRON_SEQ_ABORT_EN to add an Abort input that
// cuts a running sequence short through a final idle (POST) phase.
module dekatron_step_sequencer
  import dekatron_pkg::*;
#(
  parameter int PRE_GAP  = DEF_PRE_GAP,
  parameter int PULSE_W  = DEF_PULSE_W,
  parameter int POST_GAP = DEF_POST_GAP,
  parameter int STEP_W   = DEF_STEP_W
) (
  input  logic              hsClk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Dec,
  input  logic [STEP_W-1:0] Steps,
`ifdef DEKATRON_SEQ_ABORT_EN
  input  logic              Abort,
`endif
  output logic              Ready,
  output logic              Busy,
  output logic              Done,
  output logic [STEP_W-1:0] StepCnt,
  output logic [1:0]        PulsesOut
);

  localparam int MAX_DUR = (PRE_GAP > PULSE_W) ?
                           ((PRE_GAP > POST_GAP) ? PRE_GAP : POST_GAP) :
                           ((PULSE_W > POST_GAP) ? PULSE_W : POST_GAP);
  localparam int TMR_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [TMR_W-1:0] PRE_LD   = TMR_W'(PRE_GAP - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] POST_LD  = TMR_W'(POST_GAP - 1);

  seqState_t         state_r;
  seqState_t         stateNext_s;
  logic              dec_r;
  logic [STEP_W-1:0] remain_r;
  logic [STEP_W-1:0] stepCnt_r;
  logic              aborted_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic [1:0]        pulses_r;

  logic              tmrLoad_s;
  logic [TMR_W-1:0]  tmrVal_s;
  logic              tmrTc_s;
  logic              accept_s;
  logic              finish_s;
  logic              stepInc_s;
  logic              remDec_s;
  logic              abortHit_s;
  logic              abortReq_s;

`ifdef DEKATRON_SEQ_ABORT_EN
  assign abortReq_s = Abort;
`else
  assign abortReq_s = 1'b0;
`endif

  dekatron_phase_timer #(
    .CNT_W (TMR_W)
  ) u_phaseTimer (
    .hsClk   (hsClk),
    .Rst_n   (Rst_n),
    .load    (tmrLoad_s),
    .loadVal (tmrVal_s),
    .tc      (tmrTc_s)
  );

  // Next-state, phase-timer reload and bookkeeping strobes.
  always_comb begin
    stateNext_s = state_r;
    tmrLoad_s   = 1'b0;
    tmrVal_s    = '0;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    stepInc_s   = 1'b0;
    remDec_s    = 1'b0;
    abortHit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          stateNext_s = PRE;
          tmrLoad_s   = 1'b1;
          tmrVal_s    = PRE_LD;
          accept_s    = 1'b1;
        end else begin
          stateNext_s = IDLE;
        end
      end
      PRE: begin
        // A zero-step request completes straight out of its first PRE cycle.
        if (remain_r == '0) begin
          stateNext_s = IDLE;
          finish_s    = 1'b1;
        end else if (tmrTc_s) begin
          stateNext_s = G1;
          tmrLoad_s   = 1'b1;
          tmrVal_s    = PULSE_LD;
        end else begin
          stateNext_s = PRE;
        end
      end
      G1: begin
        if (tmrTc_s) begin
          stateNext_s = G2;
          tmrLoad_s   = 1'b1;
          tmrVal_s    = PULSE_LD;
        end else begin
          stateNext_s = G1;
        end
      end
      G2: begin
        if (tmrTc_s) begin
          stateNext_s = POST;
          tmrLoad_s   = 1'b1;
          tmrVal_s    = POST_LD;
        end else begin
          stateNext_s = G2;
        end
      end
      POST: begin
        if (tmrTc_s) begin
          if (aborted_r) begin
            stateNext_s = IDLE;
            finish_s    = 1'b1;
          end else if (remain_r > STEP_W'(1)) begin
            stateNext_s = PRE;
            tmrLoad_s   = 1'b1;
            tmrVal_s    = PRE_LD;
            stepInc_s   = 1'b1;
            remDec_s    = 1'b1;
          end else begin
            stateNext_s = IDLE;
            finish_s    = 1'b1;
            stepInc_s   = 1'b1;
          end
        end else begin
          stateNext_s = POST;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
    // An abort drops the guides and finishes through a fresh POST phase;
    // the step in flight is not counted.
    if (abortReq_s && (state_r != IDLE)) begin
      stateNext_s = POST;
      tmrLoad_s   = 1'b1;
      tmrVal_s    = POST_LD;
      finish_s    = 1'b0;
      stepInc_s   = 1'b0;
      remDec_s    = 1'b0;
      abortHit_s  = 1'b1;
    end else begin
      abortHit_s  = 1'b0;
    end
  end

  // State register and registered status/guide outputs, decoded from the next state.
  always_ff @(posedge hsClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r  <= IDLE;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pulses_r <= 2'b00;
    end else begin
      state_r  <= stateNext_s;
      ready_r  <= (stateNext_s == IDLE);
      busy_r   <= (stateNext_s != IDLE);
      done_r   <= finish_s;
      pulses_r <= guideDrive(stateNext_s, dec_r);
    end
  end

  // Latched request fields and step progress.
  always_ff @(posedge hsClk or negedge Rst_n) begin
    if (!Rst_n) begin
      dec_r     <= 1'b0;
      remain_r  <= '0;
      stepCnt_r <= '0;
      aborted_r <= 1'b0;
    end else if (accept_s) begin
      dec_r     <= Dec;
      remain_r  <= Steps;
      stepCnt_r <= '0;
      aborted_r <= 1'b0;
    end else begin
      if (remDec_s) begin
        remain_r <= remain_r - STEP_W'(1);
      end
      if (stepInc_s) begin
        stepCnt_r <= stepCnt_r + STEP_W'(1);
      end
      if (abortHit_s) begin
        aborted_r <= 1'b1;
      end
    end
  end

  assign Ready     = ready_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign StepCnt   = stepCnt_r;
  assign PulsesOut = pulses_r;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Self-checking bench for dekatron_step_sequencer (default timing).
// Compares the DUT against a table of hand-derived vectors and against a
// cycle-offset reference model built from the step-period arithmetic.
// Define DEKATRON_SEQ_ABORT_EN to also exercise the Abort input.
module tb_dekatron_step_sequencer;

  localparam int PRE_GAP  = 2;
  localparam int PULSE_W  = 3;
  localparam int POST_GAP = 2;
  localparam int STEP_W   = 4;
  localparam int P        = PRE_GAP + 2 * PULSE_W + POST_GAP;

  logic              hsClk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Start = 1'b0;
  logic              Dec   = 1'b0;
  logic [STEP_W-1:0] Steps = '0;
`ifdef DEKATRON_SEQ_ABORT_EN
  logic              Abort = 1'b0;
`endif
  logic              Ready;
  logic              Busy;
  logic              Done;
  logic [STEP_W-1:0] StepCnt;
  logic [1:0]        PulsesOut;

  int checks = 0;
  int errors = 0;

  // Reference model state: last accepted request and the cycle it was taken.
  int cyc     = 0;
  bit haveReq = 1'b0;
  int accCyc  = 0;
  int mN      = 0;
  bit mDec    = 1'b0;

  typedef struct packed {
    logic       start;
    logic       dec;
    logic [3:0] steps;
    logic [8:0] exp;   // {Ready, Busy, Done, StepCnt, PulsesOut}
  } vec_t;

  vec_t vecs [12];

  dekatron_step_sequencer #(
    .PRE_GAP  (PRE_GAP),
    .PULSE_W  (PULSE_W),
    .POST_GAP (POST_GAP),
    .STEP_W   (STEP_W)
  ) dut (
    .hsClk     (hsClk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Dec       (Dec),
    .Steps     (Steps),
`ifdef DEKATRON_SEQ_ABORT_EN
    .Abort     (Abort),
`endif
    .Ready     (Ready),
    .Busy      (Busy),
    .Done      (Done),
    .StepCnt   (StepCnt),
    .PulsesOut (PulsesOut)
  );

  always #5 hsClk = ~hsClk;

  function automatic logic [8:0] obs();
    return {Ready, Busy, Done, StepCnt, PulsesOut};
  endfunction

  // Expected outputs after edge c, from the request's offset t into its run.
  function automatic logic [8:0] expOut(input int c);
    int t, endT, r, cnt;
    logic rdy, bsy, dn;
    logic [1:0] first, second, p;
    if (!haveReq) return {1'b1, 1'b0, 1'b0, 4'd0, 2'b00};
    t      = c - accCyc;
    endT   = (mN == 0) ? 1 : mN * P;
    first  = mDec ? 2'b01 : 2'b10;
    second = mDec ? 2'b10 : 2'b01;
    p      = 2'b00;
    if (t < endT) begin
      rdy = 1'b0; bsy = 1'b1; dn = 1'b0;
      cnt = (mN == 0) ? 0 : t / P;
      r   = t % P;
      if (r >= PRE_GAP && r < PRE_GAP + PULSE_W) p = first;
      else if (r >= PRE_GAP + PULSE_W && r < PRE_GAP + 2 * PULSE_W) p = second;
    end else begin
      rdy = 1'b1; bsy = 1'b0; dn = (t == endT); cnt = mN;
    end
    return {rdy, bsy, dn, 4'(cnt), p};
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={R,B,D,Cnt,P}=%b required=%b", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic stepCycle(input logic st, input logic d, input logic [3:0] n, input string nm);
    logic [8:0] prev;
    prev  = expOut(cyc);
    Start = st;
    Dec   = d;
    Steps = n;
    @(posedge hsClk);
    cyc++;
    if (st && prev[8]) begin
      haveReq = 1'b1; accCyc = cyc; mN = int'(n); mDec = d;
    end
    #1;
    check($sformatf("%s@%0d", nm, cyc), obs(), expOut(cyc));
  endtask

  initial begin
    // Hand-derived trace of one increment step at default timing.
    vecs[0]  = '{1'b1, 1'b0, 4'd1, 9'b0_1_0_0000_00};
    vecs[1]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_00};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_10};
    vecs[3]  = '{1'b0, 1'b1, 4'd7, 9'b0_1_0_0000_10};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_10};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_01};
    vecs[6]  = '{1'b1, 1'b1, 4'd3, 9'b0_1_0_0000_01};
    vecs[7]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_01};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_00};
    vecs[9]  = '{1'b0, 1'b0, 4'd0, 9'b0_1_0_0000_00};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 9'b1_0_1_0001_00};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 9'b1_0_0_0001_00};

    // Reset state.
    #12;
    check("reset", obs(), {1'b1, 1'b0, 1'b0, 4'd0, 2'b00});
    @(negedge hsClk);
    Rst_n = 1'b1;
    stepCycle(1'b0, 1'b0, 4'd0, "idle");

    // Table-driven single step, Dec=0, Steps=1.
    for (int i = 0; i < 12; i++) begin
      logic [8:0] prev;
      prev  = expOut(cyc);
      Start = vecs[i].start;
      Dec   = vecs[i].dec;
      Steps = vecs[i].steps;
      @(posedge hsClk);
      cyc++;
      if (vecs[i].start && prev[8]) begin
        haveReq = 1'b1; accCyc = cyc; mN = int'(vecs[i].steps); mDec = vecs[i].dec;
      end
      #1;
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Dec=1, Steps=3, with a Start at E0+12 that must be ignored.
    stepCycle(1'b1, 1'b1, 4'd3, "dec3");
    for (int i = 1; i <= 31; i++) begin
      if (i == 12) stepCycle(1'b1, 1'b0, 4'd7, "dec3_ign");
      else         stepCycle(1'b0, 1'b0, 4'd0, "dec3");
    end
    check("dec3_final", obs(), {1'b1, 1'b0, 1'b0, 4'd3, 2'b00});

    // Steps=0, then a Start in the Done cycle (zero dead cycles).
    stepCycle(1'b1, 1'b0, 4'd0, "zero_acc");
    stepCycle(1'b0, 1'b0, 4'd0, "zero_done");
    check("zero_done_exp", obs(), {1'b1, 1'b0, 1'b1, 4'd0, 2'b00});
    stepCycle(1'b1, 1'b1, 4'd2, "b2b_acc");
    check("b2b_busy", obs(), {1'b0, 1'b1, 1'b0, 4'd0, 2'b00});
    for (int i = 1; i <= 20; i++) stepCycle(1'b0, 1'b0, 4'd0, "b2b");
    check("b2b_done", obs(), {1'b1, 1'b0, 1'b1, 4'd2, 2'b00});

    // Full-scale count: no wrap.
    stepCycle(1'b1, 1'b0, 4'd15, "max_acc");
    for (int i = 1; i <= 150; i++) stepCycle(1'b0, 1'b0, 4'd0, "max");
    check("max_done", obs(), {1'b1, 1'b0, 1'b1, 4'd15, 2'b00});
    stepCycle(1'b0, 1'b0, 4'd0, "max_hold");

    // Asynchronous reset during a Steps=5 run.
    stepCycle(1'b1, 1'b0, 4'd5, "rst_acc");
    for (int i = 1; i <= 6; i++) stepCycle(1'b0, 1'b0, 4'd0, "rst_run");
    #2;
    Rst_n = 1'b0;
    #1;
    check("rst_mid_async", obs(), {1'b1, 1'b0, 1'b0, 4'd0, 2'b00});
    haveReq = 1'b0;
    @(negedge hsClk);
    Rst_n = 1'b1;
    stepCycle(1'b0, 1'b0, 4'd0, "rst_rel");
    check("rst_rel_exp", obs(), {1'b1, 1'b0, 1'b0, 4'd0, 2'b00});

    // Randomized requests against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic st;
      logic d;
      logic [3:0] n;
      st = ($urandom_range(0, 3) == 0);
      d  = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      stepCycle(st, d, n, "rnd");
    end

`ifdef DEKATRON_SEQ_ABORT_EN
    // Abort behaviour: ignored in IDLE, loses to Start, cuts a run short.
    @(negedge hsClk);
    Rst_n = 1'b0;
    haveReq = 1'b0;
    @(negedge hsClk);
    Rst_n = 1'b1;
    Abort = 1'b1;
    stepCycle(1'b0, 1'b0, 4'd0, "ab_idle");
    stepCycle(1'b1, 1'b0, 4'd4, "ab_startwins");
    Abort = 1'b0;
    for (int i = 1; i <= 13; i++) stepCycle(1'b0, 1'b0, 4'd0, "ab_run");
    Abort = 1'b1;
    @(posedge hsClk);
    #1;
    check("ab_e14", obs(), {1'b0, 1'b1, 1'b0, 4'd1, 2'b00});
    Abort = 1'b0;
    @(posedge hsClk);
    #1;
    check("ab_e15", obs(), {1'b0, 1'b1, 1'b0, 4'd1, 2'b00});
    @(posedge hsClk);
    #1;
    check("ab_e16_done", obs(), {1'b1, 1'b0, 1'b1, 4'd1, 2'b00});
    @(posedge hsClk);
    #1;
    check("ab_e17", obs(), {1'b1, 1'b0, 1'b0, 4'd1, 2'b00});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dekatron_step_sequencer.md
Name: dekatron_step_sequencer

Overview:
- Parametrised guide-pulse generator for dekatron counter tubes. Successor to the free-running single-step pulse sender.
- Accepts a start request carrying a direction and a step count N. Emits exactly N two-phase guide-pulse sequences on the guide outputs, then signals completion.
- Pulse timing is set by parameters. Sits between the dekatron control logic (on Clk domain signals synchronised to hsClk) and the guide-electrode drivers.

Parameters:
- PRE_GAP, 2, hsClk cycles of idle (both guides low) before the first guide pulse of each step; must be ≥1.
- PULSE_W, 3, hsClk cycles each guide pulse is held high; must be ≥1.
- POST_GAP, 2, hsClk cycles of idle after the second guide pulse of each step; must be ≥1.
- STEP_W, 4, width of the step-count request and the progress counter.

Ports:
- hsClk  in  1  high-speed clock; all logic on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; accepted only when Ready=1.
- Dec  in  1  direction, sampled with Start: 0 = increment, 1 = decrement.
- Steps  in  STEP_W  number of steps to issue, sampled with Start.
- Ready  out  1  high in IDLE; Start is accepted only while high.
- Busy  out  1  high while a sequence is in progress.
- Done  out  1  one-cycle pulse when a request completes.
- StepCnt  out  STEP_W  count of steps completed in the current or last request.
- PulsesOut  out  2  guide drives {right, left}, registered.

Behaviour:
- Reset (async, Rst_n=0) forces:
  - state=IDLE; Ready=1; Busy=0; Done=0; StepCnt=0; PulsesOut=2'b00.
  - All latched request fields cleared.
- FSM states and transitions:
  - IDLE → PRE on an accepted Start.
  - PRE (PRE_GAP cycles) → G1 (PULSE_W cycles) → G2 (PULSE_W cycles) → POST (POST_GAP cycles).
  - POST end, remaining>1: → PRE.
  - POST end, otherwise: → IDLE with Done=1.
  - Implementation: a phase counter reloaded at each state entry.
- Step period: P = PRE_GAP + 2·PULSE_W + POST_GAP (10 at defaults).
- Accept at edge E0 (Start=1, Ready=1):
  - Dec, Steps are latched; StepCnt cleared to 0; Ready=0 and Busy=1 from E0.
- Guide pulse timing for step k (k = 0..N−1):
  - First guide high from edge E0+k·P+PRE_GAP for PULSE_W cycles.
  - Second guide high from the immediately following edge for PULSE_W cycles.
  - The two guides never overlap and have no gap between them.
- Guide ordering:
  - Dec=0: PulsesOut[1] fires first, then PulsesOut[0].
  - Dec=1: PulsesOut[0] fires first, then PulsesOut[1].
- StepCnt increments by 1 at the last edge of each POST phase.
- Completion at edge E0+N·P:
  - Done=1 for one cycle; Ready=1; Busy=0; StepCnt=N (held until the next accepted Start).
- Steps=0: accepted; next cycle Done=1 and Ready=1, no pulses issued, StepCnt=0.
- Start while Busy: ignored, no queueing. Changes on Dec or Steps during Busy have no effect.
- Start in the same cycle Done is high: accepted, since Ready=1 in that cycle. Back-to-back requests have zero dead cycles.
- Steps=2^STEP_W−1: issues the full count; StepCnt does not wrap.
- Rst_n asserted mid-sequence: outputs drop low immediately (async). No partial step is resumed after reset.

Optional Feature:
- Macro: DEKATRON_SEQ_ABORT_EN.
- Defined:
  - Adds input Abort (1 bit).
  - Abort=1 while Busy forces PulsesOut=00 at the next edge and enters a POST phase of POST_GAP cycles.
  - Then goes to IDLE with Done=1; StepCnt holds the steps fully completed.
  - Abort in IDLE is ignored.
  - Abort and Start in the same IDLE cycle: Start wins.
- Undefined: no Abort port; a sequence always runs to completion.

Decomposition:
- Package dekatron_pkg holds:
  - state enum typedef (IDLE, PRE, G1, G2, POST);
  - guide index constants GUIDE_RIGHT=1, GUIDE_LEFT=0;
  - default timing constants.
- One natural sub-module, dekatron_phase_timer: a loadable down-counter with a terminal-count flag, reused for the PRE, G1, G2 and POST durations.

Test Plan:
- Reset check: Rst_n=0 → Ready=1, Busy=0, Done=0, PulsesOut=00, StepCnt=0.
- Defaults, Start with Dec=0, Steps=1 at E0:
  - PulsesOut=10 during cycles E0+2..E0+4;
  - PulsesOut=01 during E0+5..E0+7;
  - Done=1 at E0+10; StepCnt=1.
- Dec=1, Steps=3:
  - three sequences of 01 then 10, at period 10;
  - Done at E0+30; StepCnt=3;
  - a Start at E0+12 is ignored.
- Steps=0 → Done=1 the cycle after accept, no pulses. Then a Start in the Done cycle with Steps=2 → accepted, Done at +20.
- Reset at E0+6 of a Steps=5 run → outputs low immediately; after release, Ready=1 and StepCnt=0.
- DEKATRON_SEQ_ABORT_EN, Steps=4, Abort at E0+13 → PulsesOut=00 from E0+14; Done=1 at E0+16; StepCnt=1.
